// File: rtl/conv1d_pool_layer.sv
// 1-D convolution, max-pool and bias layer with bias/weight load FSM.
// Optional ReLU on the output when CONV1D_RELU_EN is defined.
module conv1d_pool_layer #(
  parameter int DW     = 32,
  parameter int IN_CH  = 2,
  parameter int OUT_CH = 4,
  parameter int KSIZE  = 3,
  parameter int POOL   = 2
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic                 i_EN_w,
  input  logic                 i_EN_c,
  output logic                 o_busy,
  input  logic [DW*IN_CH-1:0]  i_data,
  input  logic                 i_stb_in,
  output logic                 o_ack_in,
  output logic [DW*OUT_CH-1:0] o_data,
  output logic                 o_stb_out,
  input  logic                 i_ack_out
);

  localparam int NB = (OUT_CH + IN_CH - 1) / IN_CH;
  localparam int CW = $clog2(OUT_CH*KSIZE + NB + KSIZE + POOL + 2);

  typedef enum logic [1:0] {
    IDLE,
    BIAS,
    LOAD,
    COMP
  } state_t;

  state_t r_state;

  logic [CW-1:0] r_bcnt;
  logic [CW-1:0] r_lm;
  logic [CW-1:0] r_lk;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] r_pcnt;
  logic          r_stb;

  logic signed [DW-1:0] r_bias [OUT_CH];
  logic signed [DW-1:0] r_w    [OUT_CH][KSIZE][IN_CH];
  logic signed [DW-1:0] r_win  [KSIZE][IN_CH];
  logic signed [DW-1:0] r_max  [OUT_CH];
  logic signed [DW-1:0] r_out  [OUT_CH];

  logic signed [DW-1:0] w_tap  [KSIZE][IN_CH];
  logic signed [DW-1:0] w_conv [OUT_CH];
  logic signed [DW-1:0] w_nmax [OUT_CH];
  logic signed [DW-1:0] w_res  [OUT_CH];

  logic w_hold;
  logic w_xfer;
  logic w_full;
  logic w_last;

  assign w_hold    = r_stb && !i_ack_out;
  assign o_ack_in  = (r_state == BIAS) || (r_state == LOAD) ||
                     ((r_state == COMP) && !w_hold);
  assign w_xfer    = i_stb_in && o_ack_in;
  assign w_full    = (r_fill == CW'(KSIZE-1));
  assign w_last    = (r_pcnt == CW'(POOL-1));
  assign o_busy    = (r_state != IDLE) || r_stb;
  assign o_stb_out = r_stb;

  // window as it looks after shifting in the current beat (tap 0 oldest)
  always_comb begin
    for (int k = 0; k < KSIZE-1; k++)
      for (int j = 0; j < IN_CH; j++)
        w_tap[k][j] = r_win[k+1][j];
    for (int j = 0; j < IN_CH; j++)
      w_tap[KSIZE-1][j] = i_data[j*DW +: DW];
  end

  // convolution, running max and biased (optionally rectified) result
  always_comb begin
    for (int m = 0; m < OUT_CH; m++) begin
      w_conv[m] = '0;
      for (int k = 0; k < KSIZE; k++)
        for (int j = 0; j < IN_CH; j++)
          w_conv[m] = w_conv[m] + r_w[m][k][j] * w_tap[k][j];
      if ((r_pcnt == '0) || (w_conv[m] > r_max[m]))
        w_nmax[m] = w_conv[m];
      else
        w_nmax[m] = r_max[m];
      w_res[m] = w_nmax[m] + r_bias[m];
`ifdef CONV1D_RELU_EN
      if (w_res[m][DW-1])
        w_res[m] = '0;
`endif
    end
  end

  // pack registered channel results onto the output bus
  always_comb begin
    o_data = '0;
    for (int m = 0; m < OUT_CH; m++)
      o_data[m*DW +: DW] = r_out[m];
  end

  // control FSM, parameter storage, window and pooling state
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_lm    <= '0;
      r_lk    <= '0;
      r_fill  <= '0;
      r_pcnt  <= '0;
      r_stb   <= 1'b0;
      for (int m = 0; m < OUT_CH; m++) begin
        r_bias[m] <= '0;
        r_max[m]  <= '0;
        r_out[m]  <= '0;
        for (int k = 0; k < KSIZE; k++)
          for (int j = 0; j < IN_CH; j++)
            r_w[m][k][j] <= '0;
      end
      for (int k = 0; k < KSIZE; k++)
        for (int j = 0; j < IN_CH; j++)
          r_win[k][j] <= '0;
    end else begin
      if (r_stb && i_ack_out)
        r_stb <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_EN_w) begin
            r_state <= BIAS;
            r_bcnt  <= '0;
          end else if (i_EN_c) begin
            r_state <= COMP;
          end
        end
        BIAS: begin
          if (w_xfer) begin
            for (int m = 0; m < OUT_CH; m++)
              for (int j = 0; j < IN_CH; j++)
                if (int'(r_bcnt)*IN_CH + j == m)
                  r_bias[m] <= i_data[j*DW +: DW];
            if (r_bcnt == CW'(NB-1)) begin
              r_bcnt  <= '0;
              r_lm    <= '0;
              r_lk    <= '0;
              r_state <= LOAD;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_xfer) begin
            for (int m = 0; m < OUT_CH; m++)
              for (int k = 0; k < KSIZE; k++)
                if (r_lm == CW'(m) && r_lk == CW'(k))
                  for (int j = 0; j < IN_CH; j++)
                    r_w[m][k][j] <= i_data[j*DW +: DW];
            if (r_lk == CW'(KSIZE-1)) begin
              r_lk <= '0;
              if (r_lm == CW'(OUT_CH-1)) begin
                r_lm    <= '0;
                r_state <= IDLE;
              end else begin
                r_lm <= r_lm + 1'b1;
              end
            end else begin
              r_lk <= r_lk + 1'b1;
            end
          end
        end
        COMP: begin
          if (!i_EN_c) begin
            if (!w_hold) begin
              r_state <= IDLE;
              r_fill  <= '0;
              r_pcnt  <= '0;
            end
          end else if (w_xfer) begin
            r_win <= w_tap;
            if (!w_full) begin
              r_fill <= r_fill + 1'b1;
            end else begin
              r_max <= w_nmax;
              if (w_last) begin
                r_out  <= w_res;
                r_stb  <= 1'b1;
                r_pcnt <= '0;
              end else begin
                r_pcnt <= r_pcnt + 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_pool_layer.sv
// Self-checking bench for conv1d_pool_layer (DW=16, 2 in, 4 out, K=3, P=2)
// plus a 3-output-channel instance for the partial bias beat.
module tb_conv1d_pool_layer;

  localparam int K = 3;
  localparam int P = 2;

  logic        clk;
  logic        RSTn;
  logic        i_EN_w;
  logic        i_EN_c;
  logic        o_busy;
  logic [31:0] i_data;
  logic        i_stb_in;
  logic        o_ack_in;
  logic [63:0] o_data;
  logic        o_stb_out;
  logic        i_ack_out;

  logic        s3_en_w;
  logic        s3_en_c;
  logic        s3_busy;
  logic [31:0] s3_data;
  logic        s3_stb_in;
  logic        s3_ack_in;
  logic [47:0] s3_odata;
  logic        s3_stb_out;
  logic        s3_ack_out;

  conv1d_pool_layer #(
    .DW(16), .IN_CH(2), .OUT_CH(4), .KSIZE(3), .POOL(2)
  ) u_dut (
    .clk(clk), .RSTn(RSTn),
    .i_EN_w(i_EN_w), .i_EN_c(i_EN_c), .o_busy(o_busy),
    .i_data(i_data), .i_stb_in(i_stb_in), .o_ack_in(o_ack_in),
    .o_data(o_data), .o_stb_out(o_stb_out), .i_ack_out(i_ack_out)
  );

  conv1d_pool_layer #(
    .DW(16), .IN_CH(2), .OUT_CH(3), .KSIZE(3), .POOL(2)
  ) u_dut3 (
    .clk(clk), .RSTn(RSTn),
    .i_EN_w(s3_en_w), .i_EN_c(s3_en_c), .o_busy(s3_busy),
    .i_data(s3_data), .i_stb_in(s3_stb_in), .o_ack_in(s3_ack_in),
    .o_data(s3_odata), .o_stb_out(s3_stb_out), .i_ack_out(s3_ack_out)
  );

  typedef struct packed {
    logic [63:0]  bias;
    logic [15:0]  wt;
    logic [127:0] beats;
    logic [63:0]  exp;
  } vec_t;

  vec_t        tv [5];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          rand_ack = 0;
  logic [15:0] m_bias [4];
  logic [15:0] m_w [4][3][2];
  logic [63:0] got_q [$];
  logic [63:0] exp_q [$];
  logic [31:0] beats_q [$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial forever begin
    @(negedge clk);
    if (RSTn && o_stb_out && i_ack_out)
      got_q.push_back(o_data);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ack)
      i_ack_out = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] relu16(input logic [15:0] v);
`ifdef CONV1D_RELU_EN
    return v[15] ? 16'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [63:0] relu64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 4; i++)
      r[i*16 +: 16] = relu16(v[i*16 +: 16]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d);
    logic a;
    bit   ok;
    ok       = 0;
    i_data   = d;
    i_stb_in = 1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      a = o_ack_in;
      tick();
      if (a) begin
        ok = 1;
        break;
      end
    end
    i_stb_in = 0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: got no ack expected ack");
    end
  endtask

  task automatic load_model();
    i_EN_w = 1;
    tick();
    i_EN_w = 0;
    for (int b = 0; b < 2; b++)
      send_beat({m_bias[2*b+1], m_bias[2*b]});
    for (int n = 0; n < 12; n++)
      send_beat({m_w[n/3][n%3][1], m_w[n/3][n%3][0]});
  endtask

  task automatic set_uniform(input logic [63:0] b, input logic [15:0] w);
    for (int m = 0; m < 4; m++) begin
      m_bias[m] = b[m*16 +: 16];
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 2; j++)
          m_w[m][k][j] = w;
    end
  endtask

  task automatic enter_comp();
    i_EN_c = 1;
    tick();
  endtask

  task automatic exit_comp();
    bit ok;
    ok     = 0;
    i_EN_c = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1;
        break;
      end
    end
    tick();
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 300; t++) begin
      if (got_q.size() >= n)
        break;
      tick();
    end
  endtask

  function automatic logic [63:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // reference: slide a K-beat window over the stream, pool in groups of P
  task automatic model();
    logic [63:0]          conv [$];
    logic [63:0]          cv;
    logic [63:0]          o;
    logic [31:0]          b;
    logic signed [15:0]   x;
    logic signed [15:0]   wv;
    logic signed [15:0]   mx;
    logic signed [15:0]   c;
    int                   acc;
    for (int i = K-1; i < beats_q.size(); i++) begin
      for (int m = 0; m < 4; m++) begin
        acc = 0;
        for (int k = 0; k < K; k++) begin
          b = beats_q[i-K+1+k];
          for (int j = 0; j < 2; j++) begin
            x   = b[j*16 +: 16];
            wv  = m_w[m][k][j];
            acc = acc + int'(wv) * int'(x);
          end
        end
        cv[m*16 +: 16] = acc[15:0];
      end
      conv.push_back(cv);
    end
    for (int g = 0; g < conv.size() / P; g++) begin
      for (int m = 0; m < 4; m++) begin
        cv = conv[g*P];
        mx = cv[m*16 +: 16];
        for (int p = 1; p < P; p++) begin
          cv = conv[g*P+p];
          c  = cv[m*16 +: 16];
          if (c > mx)
            mx = c;
        end
        o[m*16 +: 16] = relu16(mx + m_bias[m]);
      end
      exp_q.push_back(o);
    end
  endtask

  initial begin
    logic [31:0] d;

    tv[0] = '{64'h0003_0002_0001_0000, 16'h0001,
              {4{32'h0001_0001}}, 64'h0009_0008_0007_0006};
    tv[1] = '{64'hFFEC_FFEC_FFEC_FFEC, 16'h0001,
              {4{32'h0001_0001}}, 64'hFFF2_FFF2_FFF2_FFF2};
    tv[2] = '{64'h0000_0000_0000_0005, 16'h0002,
              128'hFFFFFFFF_00060005_00040003_00020001,
              64'h002A_002A_002A_002F};
    tv[3] = '{64'h0000_0000_0000_0000, 16'hFFFF,
              128'hFFFFFFFF_00060005_00040003_00020001,
              64'hFFF0_FFF0_FFF0_FFF0};
    tv[4] = '{64'h0001_0001_0001_0001, 16'h4000,
              {4{32'h0000_0002}}, 64'h8001_8001_8001_8001};

    RSTn       = 0;
    i_EN_w     = 0;
    i_EN_c     = 0;
    i_data     = 0;
    i_stb_in   = 0;
    i_ack_out  = 1;
    s3_en_w    = 0;
    s3_en_c    = 0;
    s3_data    = 0;
    s3_stb_in  = 0;
    s3_ack_out = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stb", 64'(o_stb_out), 64'd0);
    check("rst_ack", 64'(o_ack_in), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_data", o_data, 64'd0);
    RSTn = 1;
    tick();

    // OUT_CH=3: second bias beat lane 1 must be dropped
    s3_en_w = 1;
    tick();
    s3_en_w   = 0;
    s3_stb_in = 1;
    s3_data   = 32'h000B_000A;
    @(negedge clk);
    check("oc3_bias_ack", 64'(s3_ack_in), 64'd1);
    tick();
    s3_data = 32'h0077_000C;
    tick();
    s3_data = 32'h0;
    repeat (9) tick();
    s3_stb_in = 0;
    @(negedge clk);
    check("oc3_idle", 64'(s3_busy), 64'd0);
    tick();
    s3_en_c = 1;
    tick();
    s3_data   = 32'h0001_0001;
    s3_stb_in = 1;
    repeat (4) tick();
    s3_stb_in = 0;
    @(negedge clk);
    check("oc3_stb", 64'(s3_stb_out), 64'd1);
    check("oc3_data", 64'(s3_odata), 64'h0000_000C_000B_000A);
    tick();
    s3_en_c = 0;

    // table of single-output streams
    for (int v = 0; v < 5; v++) begin
      set_uniform(tv[v].bias, tv[v].wt);
      load_model();
      got_q.delete();
      enter_comp();
      for (int b = 0; b < 4; b++)
        send_beat(tv[v].beats[b*32 +: 32]);
      wait_out(1);
      repeat (3) tick();
      check($sformatf("vec%0d_count", v), 64'(got_q.size()), 64'd1);
      check($sformatf("vec%0d_data", v), got_at(0), relu64(tv[v].exp));
      exit_comp();
    end

    // backpressure: hold ack low for 5 cycles with a beat waiting
    set_uniform(tv[0].bias, tv[0].wt);
    load_model();
    got_q.delete();
    i_ack_out = 0;
    enter_comp();
    for (int b = 0; b < 4; b++)
      send_beat(32'h0001_0001);
    i_data   = 32'h0001_0001;
    i_stb_in = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_ack_low", 64'(o_ack_in), 64'd0);
      check("bp_data_hold", o_data, 64'h0009_0008_0007_0006);
      tick();
    end
    i_ack_out = 1;
    @(negedge clk);
    check("bp_both_hs", 64'(o_ack_in), 64'd1);
    tick();
    i_stb_in = 0;
    @(negedge clk);
    check("bp_stb_drop", 64'(o_stb_out), 64'd0);
    tick();
    send_beat(32'h0001_0001);
    wait_out(2);
    repeat (2) tick();
    check("bp_count", 64'(got_q.size()), 64'd2);
    check("bp_next_data", got_at(1), 64'h0009_0008_0007_0006);
    exit_comp();

    // leaving compute restarts window priming
    got_q.delete();
    enter_comp();
    send_beat(32'h0001_0001);
    send_beat(32'h0001_0001);
    exit_comp();
    enter_comp();
    for (int b = 0; b < 3; b++)
      send_beat(32'h0001_0001);
    repeat (4) tick();
    check("prime_none", 64'(got_q.size()), 64'd0);
    send_beat(32'h0001_0001);
    wait_out(1);
    repeat (2) tick();
    check("prime_count", 64'(got_q.size()), 64'd1);
    check("prime_data", got_at(0), 64'h0009_0008_0007_0006);
    exit_comp();

    // reset during weight beat 5, then full reload
    i_EN_w = 1;
    tick();
    i_EN_w = 0;
    send_beat({m_bias[1], m_bias[0]});
    send_beat({m_bias[3], m_bias[2]});
    for (int n = 0; n < 4; n++)
      send_beat(32'h0001_0001);
    i_data   = 32'h0001_0001;
    i_stb_in = 1;
    @(negedge clk);
    RSTn = 0;
    #1;
    check("mrst_stb", 64'(o_stb_out), 64'd0);
    check("mrst_ack", 64'(o_ack_in), 64'd0);
    check("mrst_busy", 64'(o_busy), 64'd0);
    check("mrst_data", o_data, 64'd0);
    @(posedge clk);
    #1;
    i_stb_in = 0;
    RSTn     = 1;
    tick();
    got_q.delete();
    load_model();
    enter_comp();
    for (int b = 0; b < 4; b++)
      send_beat(32'h0001_0001);
    wait_out(1);
    repeat (2) tick();
    check("mrst_reload", got_at(0), 64'h0009_0008_0007_0006);
    exit_comp();

    // randomized streams with random output backpressure
    for (int r = 0; r < 3; r++) begin
      for (int m = 0; m < 4; m++) begin
        m_bias[m] = 16'($urandom);
        for (int k = 0; k < 3; k++)
          for (int j = 0; j < 2; j++)
            m_w[m][k][j] = 16'($urandom_range(0, 15)) - 16'd8;
      end
      load_model();
      beats_q.delete();
      got_q.delete();
      exp_q.delete();
      rand_ack = 1;
      enter_comp();
      for (int i = 0; i < 20; i++) begin
        d = $urandom;
        beats_q.push_back(d);
        repeat ($urandom_range(0, 2)) tick();
        send_beat(d);
      end
      model();
      wait_out(exp_q.size());
      rand_ack  = 0;
      i_ack_out = 1;
      repeat (2) tick();
      check($sformatf("rnd%0d_count", r), 64'(got_q.size()),
            64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("rnd%0d_out%0d", r, i), got_at(i), exp_q[i]);
      exit_comp();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv1d_pool_layer.md
CONV1D_POOL_LAYER -- requirements
Module: conv1d_pool_layer

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning signed two's-complement word width.
REQ-002 The block SHALL have parameter IN_CH, default 2, meaning input channels per beat.
REQ-003 The block SHALL have parameter OUT_CH, default 4, meaning output channels, any value >=1, not required to be a multiple of IN_CH.
REQ-004 The block SHALL have parameter KSIZE, default 3, meaning kernel taps, >=1.
REQ-005 The block SHALL have parameter POOL, default 2, meaning non-overlapping max-pool factor, >=1.
REQ-006 The block SHALL have port clk, input, width 1, the clock; all state changes on its rising edge.
REQ-007 The block SHALL have port RSTn, input, width 1, the reset, asynchronous, active-low.
REQ-008 The block SHALL have port i_EN_w, input, width 1, a request to start a bias+weight load from IDLE.
REQ-009 The block SHALL have port i_EN_c, input, width 1, the compute-mode enable.
REQ-010 The block SHALL have port o_busy, output, width 1, high when state!=IDLE or an output is pending.
REQ-011 The block SHALL have port i_data, input, width DW*IN_CH, lane j at bits [j*DW +: DW].
REQ-012 The block SHALL have ports i_stb_in (input, width 1) and o_ack_in (output, width 1), the input handshake; a beat transfers when both are high on a clock edge.
REQ-013 The block SHALL have port o_data, output, width DW*OUT_CH, channel m at bits [m*DW +: DW].
REQ-014 The block SHALL have ports o_stb_out (output, width 1) and i_ack_out (input, width 1), the output handshake.

Function
REQ-015 The FSM SHALL have states IDLE, BIAS, LOAD and COMP; from IDLE, i_EN_w moves to BIAS, else i_EN_c moves to COMP, and i_EN_w SHALL win when both are high.
REQ-016 BIAS SHALL accept ceil(OUT_CH/IN_CH) beats; beat b lane j is written to bias[b*IN_CH+j], and lanes with index >=OUT_CH are discarded; after the last beat the FSM SHALL go to LOAD.
REQ-017 LOAD SHALL accept OUT_CH*KSIZE beats; beat n lane j is written to weight[n/KSIZE][n%KSIZE][j]; after the last beat the FSM SHALL go to IDLE.
REQ-018 In BIAS and LOAD, o_ack_in SHALL be 1 every cycle.
REQ-019 COMP SHALL shift each accepted beat into a KSIZE-deep window; the first KSIZE-1 beats only prime the window.
REQ-020 Every subsequent beat in COMP SHALL produce conv[m] = sum over k,j of weight[m][k][j]*win[k][j], where tap 0 is the oldest sample and tap KSIZE-1 is the new beat.
REQ-021 Products and sums SHALL be truncated to DW bits (wrap, no saturation).
REQ-022 A running per-channel maximum SHALL cover POOL consecutive conv results, using a signed compare where the first result of a group loads unconditionally.
REQ-023 On the POOL-th result, o_data[m] SHALL be registered as max[m]+bias[m] (DW wrap), and o_stb_out SHALL rise the cycle after that input handshake.
REQ-024 o_stb_out and o_data SHALL stay stable until i_ack_out is sampled high; o_stb_out SHALL drop the next cycle unless a new result is registered on that same edge.
REQ-025 While o_stb_out=1 and i_ack_out=0, o_ack_in SHALL be 0 in COMP (backpressure); otherwise o_ack_in SHALL be 1 in COMP.
REQ-026 When i_EN_c deasserts in COMP, the FSM SHALL return to IDLE once no output is pending; the window fill count and the pool count SHALL clear; weights and biases SHALL be kept.
REQ-027 i_EN_w SHALL be ignored outside IDLE, and i_stb_in SHALL be ignored in IDLE.
REQ-028 If i_stb_in=1 and i_ack_out=1 on the edge where o_stb_out is high, both handshakes SHALL complete.

Reset
REQ-029 On RSTn low, state SHALL be IDLE; o_stb_out, o_ack_in and o_busy SHALL be 0; o_data SHALL be 0; all counters, window contents, weights and biases SHALL be 0.
REQ-030 A reset mid-load or mid-compute SHALL abandon the operation with no partial output.

Configuration
REQ-031 With CONV1D_RELU_EN defined, o_data[m] SHALL be 0 when max[m]+bias[m] is negative; without it, the signed value SHALL pass unchanged.

Verification (DW=16, IN_CH=2, OUT_CH=4, KSIZE=3, POOL=2)
REQ-032 Load bias {0,1},{2,3} and all weights 1, then stream 4 beats of {1,1} -> exactly one output, o_data={9,8,7,6} for ch3..ch0.
REQ-033 Load bias 0 with OUT_CH=3 (2 bias beats) -> the second beat's lane 1 is discarded and bias[2] equals lane 0.
REQ-034 Hold i_ack_out=0 for 5 cycles after o_stb_out -> o_ack_in=0 and o_data stays stable; after ack, the next input is accepted.
REQ-035 Use weights 1, bias -20 and inputs {1,1} -> o_data=-14 without CONV1D_RELU_EN and 0 with it.
REQ-036 Pulse RSTn low during LOAD beat 5 -> all outputs 0 and state IDLE; a full reload then gives the REQ-032 result.
REQ-037 Drop i_EN_c after 2 beats, then re-enter COMP -> priming restarts, and the first output comes only after 4 new beats.
